// File: rtl/one_hot_rr_arbiter.sv
// Round-robin arbiter issuing registered one-hot grants to N requesters,
// with break-before-make hand-off and a maximum-hold timeout.
// Ports: clk, rst_n (sync, active-low), en, req[N] in;
//        gnt[N], gnt_valid, gnt_idx[IDX_W], timeout out (all registered).
module one_hot_rr_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int IDX_W    = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] ptr;
    logic [7:0]       hold_cnt;

    logic [N-1:0]     gnt_d;
    logic [IDX_W-1:0] idx_d;
    logic             timeout_d;
    logic [IDX_W-1:0] ptr_d;
    logic [7:0]       hold_d;

    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic             cur_req;
    logic             hold_max;
    logic             release_now;
    logic [IDX_W-1:0] ptr_next;

    // Scan ptr, ptr+1, ... wrapping mod N; first set request wins.
    always_comb begin
        int j;
        win_found = 1'b0;
        win_idx   = '0;
        j         = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!win_found && req[j]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(j);
            end
        end
    end

    assign cur_req     = req[gnt_idx];
    assign hold_max    = (hold_cnt == 8'(MAX_HOLD));
    assign release_now = !cur_req || hold_max;
    // The releasing requester becomes lowest priority next round.
    assign ptr_next    = (gnt_idx == IDX_W'(N - 1)) ? '0
                                                    : gnt_idx + 1'b1;

    // State register together with the registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_idx   <= '0;
            timeout   <= 1'b0;
            ptr       <= '0;
            hold_cnt  <= '0;
        end else begin
            state_q   <= state_d;
            gnt       <= gnt_d;
            gnt_valid <= |gnt_d;
            gnt_idx   <= idx_d;
            timeout   <= timeout_d;
            ptr       <= ptr_d;
            hold_cnt  <= hold_d;
        end
    end

    // Next-state logic; disabling always returns to IDLE.
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (win_found) state_d = GRANT;
                GRANT:   if (release_now) state_d = GAP;
                GAP:     state_d = win_found ? GRANT : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Next values of the registered outputs and bookkeeping.
    always_comb begin
        gnt_d     = '0;
        idx_d     = gnt_idx;
        timeout_d = 1'b0;
        ptr_d     = ptr;
        hold_d    = '0;
        if (en) begin
            unique case (state_q)
                IDLE, GAP: begin
                    if (win_found) begin
                        gnt_d[win_idx] = 1'b1;
                        idx_d          = win_idx;
                        hold_d         = 8'd1;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        ptr_d = ptr_next;
                        // Forced release only if the owner still wants it.
                        timeout_d = cur_req;
                    end else begin
                        gnt_d  = gnt;
                        hold_d = hold_cnt + 8'd1;
                    end
                end
                default: begin
                    gnt_d = '0;
                end
            endcase
        end
    end

endmodule
